// File: rtl/lsu_access_ctrl_pkg.sv
// Shared sizes, FSM state type and alignment helpers
// for the LSU access control stage.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] a
    );
        logic m;
        m = 1'b0;
        case (size)
            SIZE_H:  m = a[0];
            SIZE_W:  m = |a;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    // Index of the final byte beat of a split access.
    function automatic logic [1:0] last_beat(input logic [1:0] size);
        logic [1:0] n;
        n = 2'd0;
        case (size)
            SIZE_H:  n = 2'd1;
            SIZE_W:  n = 2'd3;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_access_ctrl_if.sv
// Request, response and data-memory bus of the LSU access stage.
// slave is the LSU view; master is the MEM stage plus memory view.
interface lsu_access_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  size;
    logic        SiUned;
    logic [31:0] addr;
    logic [31:0] WMemData;
    logic [31:0] DataRead;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned,
        input  req_addr, req_wdata, DataRead, rsp_ready,
        output req_ready, MemRead, MemWrite, size, SiUned,
        output addr, WMemData, rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned,
        output req_addr, req_wdata, DataRead, rsp_ready,
        input  req_ready, MemRead, MemWrite, size, SiUned,
        input  addr, WMemData, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/lsu_access_ctrl_load_extend.sv
// Sign/zero extension of an assembled load word by access size.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic sb;
    logic sh;

    assign sb = ~unsigned_i & raw_i[7];
    assign sh = ~unsigned_i & raw_i[15];

    always_comb begin
        data_o = raw_i;
        case (size_i)
            SIZE_B:  data_o = {{24{sb}}, raw_i[7:0]};
            SIZE_H:  data_o = {{16{sh}}, raw_i[15:0]};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/lsu_access_ctrl.sv
// Load/store control in front of the data memory; splits
// misaligned half/word accesses into byte beats.
module lsu_access_ctrl
    import lsu_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic               Clk,
    input  logic               Rst_n,
    lsu_access_ctrl_if.slave   bus
);

    lsu_state_t  state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic [31:0] asm_q, asm_d;
    logic        wr_q, wr_d;
    logic        uns_q, uns_d;
    logic        mis_q, mis_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rerr_q, rerr_d;

    logic        req_mis;
    logic        req_bad;
    logic        in_acc;
    logic [7:0]  wbyte;
    logic [31:0] asm_nx;
    logic [31:0] ext_data;

    assign req_mis = misaligned(bus.req_size, bus.req_addr[1:0]);
    assign req_bad = (bus.req_size == SIZE_X) ||
                     (req_mis && !SPLIT_MISALIGNED);

    always_comb begin
        asm_nx = asm_q;
        asm_nx[{beat_q, 3'b000} +: 8] = bus.DataRead[7:0];
    end

    lsu_load_extend u_ext (
        .raw_i      (asm_nx),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ext_data)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        asm_d   = asm_q;
        wr_d    = wr_q;
        uns_d   = uns_q;
        mis_d   = mis_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_write;
                    uns_d   = bus.req_unsigned;
                    size_d  = bus.req_size;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    mis_d   = req_mis;
                    beat_d  = 2'd0;
                    asm_d   = 32'h0;
                    rdata_d = 32'h0;
                    rerr_d  = req_bad;
                    state_d = req_bad ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (!mis_q) begin
                    rdata_d = wr_q ? 32'h0 : bus.DataRead;
                    state_d = RESP;
                end else begin
                    if (!wr_q) asm_d = asm_nx;
                    if (beat_q == last_beat(size_q)) begin
                        rdata_d = wr_q ? 32'h0 : ext_data;
                        state_d = RESP;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            asm_q   <= 32'h0;
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            mis_q   <= 1'b0;
            size_q  <= SIZE_B;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            asm_q   <= asm_d;
            wr_q    <= wr_d;
            uns_q   <= uns_d;
            mis_q   <= mis_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    // Gated by Rst_n so an aborting reset cancels the beat in flight.
    assign in_acc = (state_q == ACCESS) && Rst_n;
    assign wbyte  = wdata_q[{beat_q, 3'b000} +: 8];

    assign bus.MemRead  = in_acc && !wr_q;
    assign bus.MemWrite = in_acc && wr_q;
    assign bus.size     = !in_acc ? SIZE_B :
                          (mis_q ? SIZE_B : size_q);
    assign bus.SiUned   = in_acc && (mis_q || uns_q);
    assign bus.addr     = in_acc ? addr_q + {30'h0, beat_q} : 32'h0;
    assign bus.WMemData = !in_acc ? 32'h0 :
                          (mis_q ? {24'h0, wbyte} : wdata_q);

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = bus.rsp_valid ? rdata_q : 32'h0;
    assign bus.rsp_err   = bus.rsp_valid && rerr_q;

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Scoreboard bench for lsu_access_ctrl: byte-array reference memory,
// queued expected responses and memory beats, randomized traffic.
module tb_lsu_access_ctrl;
    import lsu_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
        int          hold;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] wd;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_mem = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    rsp_t  exp_q[$];
    beat_t bq[$];

    logic [7:0] mem     [4096];
    logic [7:0] init_mem[4096];
    logic [7:0] ref_mem [4096];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_access_ctrl_if u_if ();
    lsu_access_ctrl_if u_if0 ();

    lsu_access_ctrl #(.SPLIT_MISALIGNED(1'b1)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (u_if)
    );

    lsu_access_ctrl #(.SPLIT_MISALIGNED(1'b0)) dut0 (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (u_if0)
    );

    // Data memory: combinational read, write on posedge.
    logic [11:0] ma;
    logic [31:0] mword;
    assign ma = u_if.addr[11:0];

    always_comb begin
        mword = {mem[ma + 12'd3], mem[ma + 12'd2],
                 mem[ma + 12'd1], mem[ma]};
        case (u_if.size)
            2'b00: u_if.DataRead = u_if.SiUned ? {24'h0, mword[7:0]}
                                 : {{24{mword[7]}}, mword[7:0]};
            2'b01: u_if.DataRead = u_if.SiUned ? {16'h0, mword[15:0]}
                                 : {{16{mword[15]}}, mword[15:0]};
            default: u_if.DataRead = mword;
        endcase
    end

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_mem[i];
        end else if (u_if.MemWrite) begin
            mem[ma] <= u_if.WMemData[7:0];
            if (u_if.size != 2'b00)
                mem[ma + 12'd1] <= u_if.WMemData[15:8];
            if (u_if.size == 2'b10) begin
                mem[ma + 12'd2] <= u_if.WMemData[23:16];
                mem[ma + 12'd3] <= u_if.WMemData[31:24];
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    // Reference model plus driver; called and returns on a negedge.
    task automatic issue(input bit wr, input logic [1:0] sz, input bit un,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int hold, input bit abort);
        int n;
        int waited;
        bit mis;
        rsp_t e;
        beat_t b;
        logic [31:0] v;
        logic [31:0] ba;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        mis = (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        e.err = (sz == 2'b11);
        e.hold = hold;
        v = 32'h0;
        if (!e.err) begin
            for (int k = 0; k < n; k++) begin
                ba = a + 32'(k);
                if (wr) begin
                    if (!abort || k == 0) ref_mem[ba[11:0]] = wd[8*k +: 8];
                end else begin
                    v[8*k +: 8] = ref_mem[ba[11:0]];
                end
            end
            if (!wr && !un && n == 1) v = {{24{v[7]}}, v[7:0]};
            if (!wr && !un && n == 2) v = {{16{v[15]}}, v[15:0]};
            if (mis) begin
                for (int k = 0; k < (abort ? 2 : n); k++) begin
                    b.addr = a + 32'(k);
                    b.wr = wr;
                    b.sz = 2'b00;
                    b.un = 1'b1;
                    b.wd = {24'h0, wd[8*k +: 8]};
                    bq.push_back(b);
                end
            end else begin
                b.addr = a;
                b.wr = wr;
                b.sz = sz;
                b.un = un;
                b.wd = wd;
                bq.push_back(b);
            end
        end
        e.data = (wr || e.err) ? 32'h0 : v;
        u_if.req_write = wr;
        u_if.req_size = sz;
        u_if.req_unsigned = un;
        u_if.req_addr = a;
        u_if.req_wdata = wd;
        u_if.req_valid = 1'b1;
        waited = 0;
        while (!u_if.req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk1("req_accept_timeout", u_if.req_ready, 1'b1);
        e.due = cyc + 1 + (e.err ? 0 : (mis ? n : 1));
        if (!abort) exp_q.push_back(e);
        @(negedge clk);
        u_if.req_valid = 1'b0;
    endtask

    // Response monitor: pops the scoreboard and drives rsp_ready.
    initial begin
        rsp_t cur;
        int hold_left;
        bit in_resp;
        bit chk_rr;
        u_if.rsp_ready = 1'b0;
        in_resp = 1'b0;
        chk_rr = 1'b0;
        hold_left = 0;
        cur.data = 32'h0;
        cur.err = 1'b0;
        cur.due = 0;
        cur.hold = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_resp = 1'b0;
                chk_rr = 1'b0;
                u_if.rsp_ready = 1'b0;
            end else begin
                if (chk_rr) begin
                    chk1("req_ready_after_rsp", u_if.req_ready, 1'b1);
                    chk1("rsp_valid_after_rsp", u_if.rsp_valid, 1'b0);
                    chk_rr = 1'b0;
                end
                if (u_if.rsp_valid) begin
                    if (!in_resp) begin
                        in_resp = 1'b1;
                        if (exp_q.size() == 0) begin
                            chk1("unexpected_rsp", 1'b1, 1'b0);
                            cur.hold = 0;
                        end else begin
                            cur = exp_q.pop_front();
                            check("rsp_latency", 32'(cyc), 32'(cur.due));
                        end
                        hold_left = cur.hold;
                    end
                    check("rsp_data", u_if.rsp_data, cur.data);
                    chk1("rsp_err", u_if.rsp_err, cur.err);
                    chk1("req_ready_in_resp", u_if.req_ready, 1'b0);
                    if (hold_left > 0) begin
                        u_if.rsp_ready = 1'b0;
                        hold_left--;
                    end else begin
                        u_if.rsp_ready = 1'b1;
                        in_resp = 1'b0;
                        chk_rr = 1'b1;
                    end
                end else begin
                    chk1("rsp_valid_dropped", in_resp, 1'b0);
                    in_resp = 1'b0;
                    u_if.rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Memory beat monitor.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (u_if.MemRead || u_if.MemWrite) begin
                if (bq.size() == 0) begin
                    chk1("unexpected_mem_access", 1'b1, 1'b0);
                end else begin
                    b = bq.pop_front();
                    check("beat_addr", u_if.addr, b.addr);
                    chk1("beat_memwrite", u_if.MemWrite, b.wr);
                    chk1("beat_memread", u_if.MemRead, !b.wr);
                    check("beat_size", 32'(u_if.size), 32'(b.sz));
                    chk1("beat_siuned", u_if.SiUned, b.un);
                    if (b.wr) check("beat_wdata", u_if.WMemData, b.wd);
                end
            end
        end
    end

    // Probe of the no-split instance; memory returns a fixed word.
    task automatic probe(input logic [1:0] sz, input logic [31:0] a,
                         input bit exp_err);
        int t0;
        bit seen;
        bit memop;
        seen = 1'b0;
        memop = 1'b0;
        u_if0.req_write = 1'b0;
        u_if0.req_size = sz;
        u_if0.req_unsigned = 1'b0;
        u_if0.req_addr = a;
        u_if0.req_wdata = 32'h0;
        u_if0.req_valid = 1'b1;
        chk1("p_req_ready", u_if0.req_ready, 1'b1);
        t0 = cyc;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            u_if0.req_valid = 1'b0;
            memop = memop | u_if0.MemRead | u_if0.MemWrite;
            if (u_if0.rsp_valid) begin
                seen = 1'b1;
                check("p_latency", 32'(cyc - t0), exp_err ? 32'd1 : 32'd2);
                chk1("p_err", u_if0.rsp_err, exp_err);
                check("p_data", u_if0.rsp_data,
                      exp_err ? 32'h0 : 32'hA5A5_A5A5);
            end
        end
        chk1("p_rsp_seen", seen, 1'b1);
        chk1("p_memop", memop, !exp_err);
        @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        int waited;
        for (int i = 0; i < 4096; i++) begin
            r = 8'($urandom);
            init_mem[i] = r;
            ref_mem[i] = r;
        end
        init_mem[12'h100] = 8'hBB; ref_mem[12'h100] = 8'hBB;
        init_mem[12'h101] = 8'hAA; ref_mem[12'h101] = 8'hAA;
        init_mem[12'h102] = 8'h99; ref_mem[12'h102] = 8'h99;
        init_mem[12'h103] = 8'h88; ref_mem[12'h103] = 8'h88;
        u_if.req_valid = 1'b0;
        u_if.req_write = 1'b0;
        u_if.req_size = 2'b00;
        u_if.req_unsigned = 1'b0;
        u_if.req_addr = 32'h0;
        u_if.req_wdata = 32'h0;
        u_if0.req_valid = 1'b0;
        u_if0.req_write = 1'b0;
        u_if0.req_size = 2'b00;
        u_if0.req_unsigned = 1'b0;
        u_if0.req_addr = 32'h0;
        u_if0.req_wdata = 32'h0;
        u_if0.DataRead = 32'hA5A5_A5A5;
        u_if0.rsp_ready = 1'b1;
        load_mem = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        load_mem = 1'b0;
        chk1("rst_req_ready", u_if.req_ready, 1'b1);
        chk1("rst_rsp_valid", u_if.rsp_valid, 1'b0);
        chk1("rst_memread", u_if.MemRead, 1'b0);
        chk1("rst_memwrite", u_if.MemWrite, 1'b0);
        chk1("rst_rsp_err", u_if.rsp_err, 1'b0);
        check("rst_rsp_data", u_if.rsp_data, 32'h0);
        chk1("rst0_req_ready", u_if0.req_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        probe(SIZE_W, 32'h102, 1'b1);
        probe(SIZE_H, 32'h001, 1'b1);
        probe(SIZE_X, 32'h100, 1'b1);
        probe(SIZE_W, 32'h100, 1'b0);

        issue(1'b0, SIZE_W, 1'b0, 32'h100, 32'h0, 0, 1'b0);
        issue(1'b1, SIZE_B, 1'b0, 32'h101, 32'h34, 0, 1'b0);
        issue(1'b1, SIZE_B, 1'b0, 32'h102, 32'hF2, 1, 1'b0);
        issue(1'b0, SIZE_H, 1'b0, 32'h101, 32'h0, 0, 1'b0);
        issue(1'b0, SIZE_H, 1'b1, 32'h101, 32'h0, 5, 1'b0);
        issue(1'b1, SIZE_W, 1'b0, 32'h203, 32'hDEAD_BEEF, 0, 1'b0);
        issue(1'b0, SIZE_W, 1'b0, 32'h203, 32'h0, 2, 1'b0);
        issue(1'b0, SIZE_X, 1'b0, 32'h100, 32'h0, 0, 1'b0);
        issue(1'b1, SIZE_X, 1'b0, 32'h104, 32'h1234_5678, 3, 1'b0);
        issue(1'b1, SIZE_W, 1'b0, 32'hFFFF_FFFF, 32'h1122_3344, 0, 1'b0);
        issue(1'b0, SIZE_W, 1'b0, 32'hFFFF_FFFF, 32'h0, 0, 1'b0);

        // Reset during beat 1 of a split store at 0x3.
        issue(1'b1, SIZE_W, 1'b0, 32'h3, 32'hCAFE_F00D, 0, 1'b1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk1("abort_req_ready", u_if.req_ready, 1'b1);
        chk1("abort_rsp_valid", u_if.rsp_valid, 1'b0);
        chk1("abort_memwrite", u_if.MemWrite, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, SIZE_W, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        issue(1'b0, SIZE_W, 1'b0, 32'h4, 32'h0, 0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            issue(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? SIZE_X
                      : 2'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 0) ? 32'($urandom)
                      : {28'h0, 4'($urandom)},
                  32'($urandom),
                  $urandom_range(0, 2), 1'b0);
        end

        waited = 0;
        while ((exp_q.size() != 0 || u_if.rsp_valid) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        check("rsp_left", 32'(exp_q.size()), 32'd0);
        check("beats_left", 32'(bq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
